// File: rtl/ppi_bus_master.sv
// ppi_bus_master: sequences valid/ready requests into setup/strobe/hold
// cycles on the ppi host bus and returns read data or write completion.
// All bus-facing outputs are registered so the strobes are glitch-free.
module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [2:0] address,
    output logic       rdb,
    output logic       wrb,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic       busy
);

    // Phase lengths below 1 collapse to a single cycle.
    localparam int SETUP_N  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int STROBE_N = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int HOLD_N   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_N - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_phase_done;

    logic             r_we;
    logic [2:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_oe;
    logic             r_rdb;
    logic             r_wrb;
    logic             r_rsp_valid;
    logic [7:0]       r_rdata;
    logic             r_ready;
    logic             r_busy;

    // Next-state and phase counter: the counter restarts at zero on every phase entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_accept     = 1'b0;
        w_phase_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_phase_done = 1'b1;
                    w_state_nxt  = ST_STROBE;
                    w_cnt_nxt    = '0;
                end
            end
            ST_STROBE: begin
                if (r_cnt == STROBE_LAST) begin
                    w_phase_done = 1'b1;
                    w_state_nxt  = ST_HOLD;
                    w_cnt_nxt    = '0;
                end
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_phase_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered bus outputs, request latch and response; all decoded from the next state
    // so each output changes on the same edge as the phase it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_oe        <= 1'b0;
            r_rdb       <= 1'b1;
            r_wrb       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_rdb       <= ~((w_state_nxt == ST_STROBE) && !r_we);
            r_wrb       <= ~((w_state_nxt == ST_STROBE) &&  r_we);
            r_rsp_valid <= (r_state == ST_HOLD) && w_phase_done;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_we   <= req_we;
                r_addr <= req_addr;
                r_oe   <= req_we;
                if (req_we) begin
                    r_wdata <= req_wdata;
                end
            end else if (w_state_nxt == ST_IDLE) begin
                r_oe <= 1'b0;
            end
            // Read data is sampled on the edge that closes the final strobe cycle.
            if ((r_state == ST_STROBE) && w_phase_done && !r_we) begin
                r_rdata <= data_in;
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign address   = r_addr;
    assign rdb       = r_rdb;
    assign wrb       = r_wrb;
    assign data_out  = r_wdata;
    assign data_oe   = r_oe;

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- Upstream bus sequencer for the ppi block. Converts a simple valid/ready request interface into correctly timed rdb/wrb/address/data cycles on the ppi host bus.
- Manages setup, strobe and hold phases and returns read data or write completion.
- Sits between the internal controller logic and the ppi; the top level resolves the data tristate from data_out/data_oe.

Parameters:
SETUP_CYC, 1, cycles address/data are stable before the strobe falls (values <1 treated as 1)
STROBE_CYC, 2, cycles rdb/wrb are held low (values <1 treated as 1)
HOLD_CYC, 1, cycles address/data are held after the strobe rises (values <1 treated as 1)
CNT_W, 4, phase counter width; each *_CYC must be <= 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_we  in  1  1 = write, 0 = read
req_addr  in  3  ppi register address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  data captured by the last read
address  out  3  to ppi address
rdb  out  1  active-low read strobe
wrb  out  1  active-low write strobe
data_out  out  8  write data toward ppi data bus
data_oe  out  1  1 = top level drives data_out onto the bus
data_in  in  8  resolved ppi data bus (read path)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asserted low, async) forces the following immediately: state=IDLE, rdb=1, wrb=1, data_oe=0, address=0, data_out=0, rsp_valid=0, rsp_rdata=0, req_ready=1, busy=0.
- FSM states:
  - IDLE: req_ready=1. On a clk edge with req_valid=1, latch req_we, req_addr and req_wdata, then go to SETUP. The request is accepted only in this handshake cycle; req_* is ignored at all other times.
  - SETUP: address=latched addr. data_oe=latched we; data_out=latched wdata for writes. Both strobes stay high. Remains here SETUP_CYC cycles, then goes to STROBE.
  - STROBE: wrb=0 (write) or rdb=0 (read), for exactly STROBE_CYC cycles. Address and data stay stable. For reads, rsp_rdata is loaded from data_in at the clk edge that ends the last STROBE cycle. Then goes to HOLD.
  - HOLD: strobes high. Address, data_out and data_oe are unchanged. Remains here HOLD_CYC cycles, then returns to IDLE.
- rsp_valid: 1 during the first IDLE cycle after HOLD, for both reads and writes; 0 otherwise. req_ready is also 1 in that cycle, so a new request may be accepted back-to-back.
- Timing: accept edge E. Strobe is low in cycles E+SETUP_CYC+1 .. E+SETUP_CYC+STROBE_CYC. rsp_valid is high in cycle E+SETUP_CYC+STROBE_CYC+HOLD_CYC+1. Defaults give 5 cycles from accept to response.
- rdb and wrb are never low in the same cycle, and are never low outside STROBE.
- Address and data never change while a strobe is low.
- data_oe returns to 0 on entry to IDLE. data_oe is never 1 during a read.
- address holds its last value in IDLE. rsp_rdata holds until the next read completes; write completions do not change it.
- Outputs are registered, so strobes are glitch-free.
- Reset mid-transaction: strobes and data_oe deassert asynchronously, no rsp_valid is generated, and the request is dropped.

Test Plan:
- Reset then idle: reset low for 3 cycles then release -> rdb=wrb=1, data_oe=0, address=0, req_ready=1, rsp_valid=0.
- Single write, defaults: req addr=3, we=1, wdata=0x80 -> address=3 and data_oe=1 from E+1; wrb=0 in cycles E+2..E+3 only; rsp_valid pulse at E+5; rdb stays 1 throughout.
- Single read: addr=0 with data_in driven 0xA5 -> rdb=0 in E+2..E+3; rsp_rdata=0xA5 with rsp_valid at E+5; data_oe=0 throughout.
- Back-to-back: write 0x55 to addr 1, then read addr 2 presented while the first is pending -> second request accepted in the rsp_valid cycle of the first; no overlapping strobes; rsp_rdata still holds its previous value after the write completes.
- Parameter sweep: SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 -> strobe low exactly 3 cycles, rsp_valid at E+8; address/data stable for the whole strobe.
- Reset mid-STROBE during a write -> wrb=1 and data_oe=0 asynchronously (before the next edge), no rsp_valid, and next request handled normally.
